// File: rtl/mcu_reg_wr.sv
// 68000 write-cycle front end: synchronises the bus strobes, decodes the word
// address and issues one registered write-clock pulse per mapped write.
//
// state  | meaning
// IDLE   | waiting for a write start; outputs inactive
// SETUP  | wdata/be stable, strobe not yet raised
// STROBE | wr_c[idx] high
// HOLD   | strobe low, data still held
// ACK    | dtack_n low until as_s returns high
// IGNORE | unmapped address, wait for as_s high
module mcu_reg_wr #(
    parameter int NREGS      = 16,
    parameter int AW         = 5,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sel,
    input  logic             as_n,
    input  logic             uds_n,
    input  logic             lds_n,
    input  logic             rw,
    input  logic [AW-1:0]    addr,
    input  logic [15:0]      din,
    output logic [NREGS-1:0] wr_c,
    output logic [15:0]      wdata,
    output logic [1:0]       be,
    output logic             dtack_n
);

    localparam int IW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] ACK    = 3'd4;
    localparam logic [2:0] IGNORE = 3'd5;

    localparam logic [AW:0] LIMIT = (AW + 1)'(NREGS);

    logic [1:0]    as_q, uds_q, lds_q;
    logic          as_s, uds_s, lds_s;
    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          start, in_range;

    always_ff @(posedge clock) begin
        if (reset) begin
            as_q  <= 2'b11;
            uds_q <= 2'b11;
            lds_q <= 2'b11;
        end else begin
            as_q  <= {as_q[0], as_n};
            uds_q <= {uds_q[0], uds_n};
            lds_q <= {lds_q[0], lds_n};
        end
    end

    assign as_s  = as_q[1];
    assign uds_s = uds_q[1];
    assign lds_s = lds_q[1];

    assign start    = ~as_s & sel & ~rw & (~uds_s | ~lds_s);
    assign in_range = ({1'b0, addr} < LIMIT);

    // wr_c and dtack_n are driven straight from flops so the downstream
    // register clocks never see decode glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            wr_c    <= '0;
            wdata   <= '0;
            be      <= '0;
            dtack_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (in_range) begin
                            idx   <= addr[IW-1:0];
                            wdata <= din;
                            be    <= {~uds_s, ~lds_s};
                            cnt   <= CW'(SETUP_CYC - 1);
                            state <= SETUP;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                end
                SETUP: begin
                    if (as_s) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        wr_c  <= NREGS'(1) << idx;
                        cnt   <= CW'(STROBE_CYC - 1);
                        state <= STROBE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        wr_c  <= '0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (as_s) begin
                        state <= IDLE;
                    end else begin
                        dtack_n <= 1'b0;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    if (as_s) begin
                        dtack_n <= 1'b1;
                        state   <= IDLE;
                    end
                end
                IGNORE: begin
                    if (as_s) state <= IDLE;
                end
                default: begin
                    wr_c    <= '0;
                    dtack_n <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_reg_wr.sv
// Directed bench for mcu_reg_wr with default parameters; inputs change and
// outputs are sampled on the falling clock edge.
module tb_mcu_reg_wr;

    logic        clock = 1'b0;
    logic        reset;
    logic        sel, as_n, uds_n, lds_n, rw;
    logic [4:0]  addr;
    logic [15:0] din;
    logic [15:0] wr_c;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        dtack_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mcu_reg_wr dut (
        .clock   (clock),
        .reset   (reset),
        .sel     (sel),
        .as_n    (as_n),
        .uds_n   (uds_n),
        .lds_n   (lds_n),
        .rw      (rw),
        .addr    (addr),
        .din     (din),
        .wr_c    (wr_c),
        .wdata   (wdata),
        .be      (be),
        .dtack_n (dtack_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic bus_release();
        as_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        rw    = 1'b1;
        sel   = 1'b0;
    endtask

    // Drives a write and checks everything up to dtack_n falling at E+5.
    task automatic write_body(input logic [4:0] a, input logic [15:0] d,
                              input logic u_n, input logic l_n, input logic [1:0] exp_be);
        logic [15:0] oh;
        oh    = 16'h0001 << a;
        sel   = 1'b1;
        rw    = 1'b0;
        addr  = a;
        din   = d;
        uds_n = u_n;
        lds_n = l_n;
        as_n  = 1'b0;
        step(); step();
        check("wr_c at E", 32'(wr_c), 32'h0);
        step();
        check("wdata at E+1", 32'(wdata), 32'(d));
        check("be at E+1", 32'(be), 32'(exp_be));
        check("wr_c at E+1", 32'(wr_c), 32'h0);
        check("dtack_n at E+1", 32'(dtack_n), 32'h1);
        step();
        check("wr_c at E+2", 32'(wr_c), 32'(oh));
        step();
        check("wr_c at E+3", 32'(wr_c), 32'(oh));
        check("dtack_n at E+3", 32'(dtack_n), 32'h1);
        step();
        check("wr_c at E+4", 32'(wr_c), 32'h0);
        check("wdata at E+4", 32'(wdata), 32'(d));
        check("dtack_n at E+4", 32'(dtack_n), 32'h1);
        step();
        check("dtack_n at E+5", 32'(dtack_n), 32'h0);
    endtask

    task automatic release_checked(input logic [15:0] d);
        bus_release();
        step();
        check("dtack_n 1 edge after as_n rise", 32'(dtack_n), 32'h0);
        step();
        check("dtack_n 2 edges after as_n rise", 32'(dtack_n), 32'h0);
        step();
        check("dtack_n 3 edges after as_n rise", 32'(dtack_n), 32'h1);
        check("wdata held in idle", 32'(wdata), 32'(d));
    endtask

    // Runs a cycle that must produce no strobe and no dtack at all.
    task automatic quiet_cycle(input string tag, input logic [4:0] a, input logic rd,
                               input logic [15:0] d, input logic [15:0] held);
        sel   = 1'b1;
        rw    = rd;
        addr  = a;
        din   = d;
        uds_n = 1'b0;
        lds_n = 1'b0;
        as_n  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check(tag, {15'h0, wr_c, dtack_n}, {15'h0, 16'h0, 1'b1});
        end
        bus_release();
        for (int i = 0; i < 3; i++) begin
            step();
            check(tag, {15'h0, wr_c, dtack_n}, {15'h0, 16'h0, 1'b1});
        end
        check({tag, " wdata held"}, 32'(wdata), 32'(held));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus_release();
        addr = '0;
        din  = '0;
        step(); step();
        check("reset wr_c", 32'(wr_c), 32'h0);
        check("reset wdata", 32'(wdata), 32'h0);
        check("reset be", 32'(be), 32'h0);
        check("reset dtack_n", 32'(dtack_n), 32'h1);
        reset = 1'b0;
        step();

        write_body(5'd3, 16'hA55A, 1'b0, 1'b0, 2'b11);
        release_checked(16'hA55A);

        write_body(5'd0, 16'h12FE, 1'b1, 1'b0, 2'b01);
        release_checked(16'h12FE);

        quiet_cycle("unmapped addr 20", 5'd20, 1'b0, 16'h7777, 16'h12FE);
        quiet_cycle("read addr 3", 5'd3, 1'b1, 16'h6666, 16'h12FE);

        // as_n low for a single cycle: enters SETUP, then aborts before the strobe
        sel   = 1'b1;
        rw    = 1'b0;
        addr  = 5'd7;
        din   = 16'hBEEF;
        uds_n = 1'b0;
        lds_n = 1'b0;
        as_n  = 1'b0;
        step();
        as_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        step(); step();
        check("abort wdata latched", 32'(wdata), 32'hBEEF);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort no activity", {15'h0, wr_c, dtack_n}, {15'h0, 16'h0, 1'b1});
        end
        bus_release();
        step();

        // reset while wr_c[5] is high
        sel   = 1'b1;
        rw    = 1'b0;
        addr  = 5'd5;
        din   = 16'h5A5A;
        uds_n = 1'b0;
        lds_n = 1'b0;
        as_n  = 1'b0;
        step(); step(); step(); step();
        check("pre-reset strobe", 32'(wr_c), 32'h0020);
        reset = 1'b1;
        step();
        check("mid-op reset wr_c", 32'(wr_c), 32'h0);
        check("mid-op reset dtack_n", 32'(dtack_n), 32'h1);
        check("mid-op reset wdata", 32'(wdata), 32'h0);
        check("mid-op reset be", 32'(be), 32'h0);
        reset = 1'b0;
        bus_release();
        step(); step(); step();
        write_body(5'd5, 16'hC3C3, 1'b0, 1'b0, 2'b11);
        release_checked(16'hC3C3);

        // back-to-back with a 2-cycle as_n high gap
        write_body(5'd9, 16'h1111, 1'b0, 1'b0, 2'b11);
        bus_release();
        step();
        check("gap cycle 1 wr_c", 32'(wr_c), 32'h0);
        check("gap cycle 1 dtack_n", 32'(dtack_n), 32'h0);
        step();
        check("gap cycle 2 wr_c", 32'(wr_c), 32'h0);
        write_body(5'd12, 16'h2222, 1'b0, 1'b1, 2'b10);
        release_checked(16'h2222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
